// File: rtl/nec_bus_pkg.sv
// Shared types and widths for the NEC V30 socket bus logic.
// Future IO decoders also import this package.
package nec_bus_pkg;

  localparam int NEC_ADDR_W = 20;
  localparam int NEC_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    REQ,
    DATA,
    RELEASE,
    ERR
  } nec_bus_state_t;

  // bit 0 selects the low byte (even address), bit 1 the high byte
  function automatic logic [1:0] nec_byte_en(input logic a0, input logic ube_n);
    return {~ube_n, ~a0};
  endfunction

endpackage

// File: rtl/nec_strobe_sync.sv
// Synchronizer for one asynchronous CPU strobe, with level and single-cycle
// rise/fall pulses taken from the synchronized level and its one-cycle history.
module nec_strobe_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic strobe,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= (sync_q << 1) | SYNC_STAGES'(strobe);
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/nec_bus_ctrl.sv
// NEC V30 bus-cycle controller: latches the multiplexed address, issues one
// req/ack transaction per CPU cycle, holds READY low until done, drives read data.
module nec_bus_ctrl
  import nec_bus_pkg::*;
#(
  parameter int                    SYNC_STAGES = 2,
  parameter int                    TIMEOUT     = 255,
  parameter logic [NEC_DATA_W-1:0] OPEN_BUS    = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NEC_ADDR_W-1:0] nec_ad_in,
  input  logic                  nec_astb,
  input  logic                  nec_rd_n,
  input  logic                  nec_wr_n,
  input  logic                  nec_io_n,
  input  logic                  nec_ube_n,
  output logic [NEC_DATA_W-1:0] nec_ad_out,
  output logic                  nec_ad_oe,
  output logic                  nec_ad_dir,
  output logic                  nec_ready,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic                  bus_io,
  output logic [NEC_ADDR_W-1:0] bus_addr,
  output logic [1:0]            bus_be,
  output logic [NEC_DATA_W-1:0] bus_wdata,
  input  logic [NEC_DATA_W-1:0] bus_rdata,
  input  logic                  bus_ack,
  output logic                  timeout
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic astb_fall, astb_lvl_unused, astb_rise_unused;
  logic rd_lvl, rd_rise, rd_fall;
  logic wr_lvl, wr_rise, wr_fall;

  // ASTB idles low, so its synchronizer resets low to avoid a phantom
  // address phase when reset is released.
  nec_strobe_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_astb (
    .clk     (clk),
    .reset_n (reset_n),
    .strobe  (nec_astb),
    .level   (astb_lvl_unused),
    .rise    (astb_rise_unused),
    .fall    (astb_fall)
  );

  nec_strobe_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_rd (
    .clk     (clk),
    .reset_n (reset_n),
    .strobe  (nec_rd_n),
    .level   (rd_lvl),
    .rise    (rd_rise),
    .fall    (rd_fall)
  );

  nec_strobe_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_wr (
    .clk     (clk),
    .reset_n (reset_n),
    .strobe  (nec_wr_n),
    .level   (wr_lvl),
    .rise    (wr_rise),
    .fall    (wr_fall)
  );

  nec_bus_state_t        state_q, state_nxt;
  logic [CNT_W-1:0]      cnt_q, cnt_nxt, cnt_inc;
  logic                  ready_nxt, req_nxt, we_nxt, io_nxt, oe_nxt, tmo_nxt;
  logic [NEC_ADDR_W-1:0] addr_nxt;
  logic [1:0]            be_nxt;
  logic [NEC_DATA_W-1:0] wdata_nxt, ad_out_nxt;

  assign cnt_inc = (cnt_q == CNT_W'(TIMEOUT)) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_nxt  = state_q;
    cnt_nxt    = '0;
    ready_nxt  = nec_ready;
    req_nxt    = bus_req;
    we_nxt     = bus_we;
    io_nxt     = bus_io;
    addr_nxt   = bus_addr;
    be_nxt     = bus_be;
    wdata_nxt  = bus_wdata;
    ad_out_nxt = nec_ad_out;
    oe_nxt     = nec_ad_oe;
    tmo_nxt    = 1'b0;

    case (state_q)
      IDLE: begin
        if (astb_fall) begin
          addr_nxt  = nec_ad_in;
          be_nxt    = nec_byte_en(nec_ad_in[0], nec_ube_n);
          io_nxt    = ~nec_io_n;
          ready_nxt = 1'b0;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        if ((rd_fall || wr_fall) && !rd_lvl && !wr_lvl) begin
          ready_nxt = 1'b1;
          state_nxt = ERR;
        end else if (rd_fall) begin
          req_nxt   = 1'b1;
          we_nxt    = 1'b0;
          state_nxt = REQ;
        end else if (wr_fall) begin
          req_nxt   = 1'b1;
          we_nxt    = 1'b1;
          wdata_nxt = nec_ad_in[NEC_DATA_W-1:0];
          state_nxt = REQ;
        end
      end
      REQ: begin
        // an ack on the same cycle the count expires still wins
        if (bus_ack) begin
          req_nxt   = 1'b0;
          ready_nxt = 1'b1;
          if (!bus_we) begin
            ad_out_nxt = bus_rdata;
            oe_nxt     = 1'b1;
          end
          state_nxt = DATA;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          req_nxt   = 1'b0;
          ready_nxt = 1'b1;
          tmo_nxt   = 1'b1;
          if (!bus_we) begin
            ad_out_nxt = OPEN_BUS;
            oe_nxt     = 1'b1;
          end
          state_nxt = DATA;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      DATA: begin
        if (bus_we ? wr_rise : rd_rise) begin
          oe_nxt    = 1'b0;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        oe_nxt    = 1'b0;
        state_nxt = IDLE;
      end
      ERR: begin
        if (rd_lvl && wr_lvl) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      nec_ready  <= 1'b1;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_io     <= 1'b0;
      bus_addr   <= '0;
      bus_be     <= '0;
      bus_wdata  <= '0;
      nec_ad_out <= '0;
      nec_ad_oe  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      cnt_q      <= cnt_nxt;
      nec_ready  <= ready_nxt;
      bus_req    <= req_nxt;
      bus_we     <= we_nxt;
      bus_io     <= io_nxt;
      bus_addr   <= addr_nxt;
      bus_be     <= be_nxt;
      bus_wdata  <= wdata_nxt;
      nec_ad_out <= ad_out_nxt;
      nec_ad_oe  <= oe_nxt;
      timeout    <= tmo_nxt;
    end
  end

  assign nec_ad_dir = nec_ad_oe;

endmodule

// File: tb/tb_nec_bus_ctrl.sv
// Directed bench for nec_bus_ctrl: a table of complete CPU cycles plus
// hand-written timeout, RD+WR conflict, async reset and back-to-back sequences.
module tb_nec_bus_ctrl;

  logic        clk;
  logic        reset_n;
  logic [19:0] nec_ad_in;
  logic        nec_astb, nec_rd_n, nec_wr_n, nec_io_n, nec_ube_n;
  logic [15:0] nec_ad_out;
  logic        nec_ad_oe, nec_ad_dir, nec_ready;
  logic        bus_req, bus_we, bus_io;
  logic [19:0] bus_addr;
  logic [1:0]  bus_be;
  logic [15:0] bus_wdata, bus_rdata;
  logic        bus_ack, timeout;

  nec_bus_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .nec_ad_in  (nec_ad_in),
    .nec_astb   (nec_astb),
    .nec_rd_n   (nec_rd_n),
    .nec_wr_n   (nec_wr_n),
    .nec_io_n   (nec_io_n),
    .nec_ube_n  (nec_ube_n),
    .nec_ad_out (nec_ad_out),
    .nec_ad_oe  (nec_ad_oe),
    .nec_ad_dir (nec_ad_dir),
    .nec_ready  (nec_ready),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_io     (bus_io),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_ack    (bus_ack),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int oe_cnt = 0;
  int req_cnt = 0;
  int oe_snap;

  always @(negedge clk) begin
    if (nec_ad_oe === 1'b1) oe_cnt++;
    if (bus_req === 1'b1) req_cnt++;
  end

  typedef struct {
    logic [19:0] ad;
    logic        ube_n;
    logic        io_n;
    logic        wr;
    logic [15:0] wdata;
    int          dly;
    logic [15:0] rdata;
    logic [1:0]  exp_be;
    logic        exp_io;
  } vec_t;

  vec_t vec[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic astb_pulse(input logic [19:0] ad, input logic ube_n, input logic io_n);
    nec_ad_in = ad;
    nec_ube_n = ube_n;
    nec_io_n  = io_n;
    nec_astb  = 1'b1;
    tick();
    nec_astb  = 1'b0;
  endtask

  task automatic addr_phase(input logic [19:0] ad, input logic ube_n, input logic io_n,
                            input string tag);
    astb_pulse(ad, ube_n, io_n);
    tick();
    tick();
    check({tag, "_rdy_pre"}, 32'(nec_ready), 32'd1);
    tick();
    check({tag, "_rdy_wait"}, 32'(nec_ready), 32'd0);
  endtask

  task automatic strobe_fall(input logic wr, input logic [15:0] wdata, input string tag);
    if (wr) begin
      nec_ad_in[15:0] = wdata;
      nec_wr_n = 1'b0;
    end else begin
      nec_rd_n = 1'b0;
    end
    tick();
    tick();
    check({tag, "_req_early"}, 32'(bus_req), 32'd0);
    tick();
    check({tag, "_req_lat"}, 32'(bus_req), 32'd1);
  endtask

  task automatic txn_start(input vec_t t, input string tag);
    oe_snap = oe_cnt;
    addr_phase(t.ad, t.ube_n, t.io_n, tag);
    strobe_fall(t.wr, t.wdata, tag);
    check({tag, "_addr"}, 32'(bus_addr), 32'(t.ad));
    check({tag, "_be"}, 32'(bus_be), 32'(t.exp_be));
    check({tag, "_io"}, 32'(bus_io), 32'(t.exp_io));
    check({tag, "_we"}, 32'(bus_we), 32'(t.wr));
    if (t.wr) check({tag, "_wdata"}, 32'(bus_wdata), 32'(t.wdata));
    for (int i = 0; i < t.dly; i++) tick();
    check({tag, "_rdy_before_ack"}, 32'(nec_ready), 32'd0);
    check({tag, "_req_before_ack"}, 32'(bus_req), 32'd1);
    bus_ack   = 1'b1;
    bus_rdata = t.rdata;
    tick();
    bus_ack   = 1'b0;
    check({tag, "_rdy_after_ack"}, 32'(nec_ready), 32'd1);
    check({tag, "_req_after_ack"}, 32'(bus_req), 32'd0);
    check({tag, "_tmo"}, 32'(timeout), 32'd0);
    if (!t.wr) begin
      check({tag, "_ad_out"}, 32'(nec_ad_out), 32'(t.rdata));
      check({tag, "_oe"}, 32'(nec_ad_oe), 32'd1);
      check({tag, "_dir"}, 32'(nec_ad_dir), 32'd1);
    end
  endtask

  task automatic txn_finish(input logic wr, input string tag);
    if (wr) nec_wr_n = 1'b1;
    else    nec_rd_n = 1'b1;
    tick();
    tick();
    check({tag, "_oe_hold"}, 32'(nec_ad_oe), 32'(!wr));
    tick();
    check({tag, "_oe_rel"}, 32'(nec_ad_oe), 32'd0);
    check({tag, "_dir_rel"}, 32'(nec_ad_dir), 32'd0);
    if (wr) check({tag, "_oe_never"}, 32'(oe_cnt - oe_snap), 32'd0);
    tick();
  endtask

  task automatic run_txn(input vec_t t, input string tag);
    txn_start(t, tag);
    txn_finish(t.wr, tag);
  endtask

  initial begin
    int   n;
    int   snap;
    vec_t t;

    vec[0] = '{20'h12345, 1'b0, 1'b1, 1'b0, 16'h0000, 5,   16'hBEEF, 2'b10, 1'b0};
    vec[1] = '{20'h00080, 1'b1, 1'b0, 1'b1, 16'hA55A, 0,   16'h0000, 2'b01, 1'b1};
    vec[2] = '{20'h0ABCD, 1'b0, 1'b1, 1'b1, 16'h1234, 2,   16'h0000, 2'b10, 1'b0};
    vec[3] = '{20'h003F8, 1'b0, 1'b0, 1'b0, 16'h0000, 1,   16'h5A5A, 2'b11, 1'b1};
    vec[4] = '{20'hFFFFE, 1'b1, 1'b1, 1'b0, 16'h0000, 3,   16'h0001, 2'b01, 1'b0};
    vec[5] = '{20'h00001, 1'b1, 1'b1, 1'b0, 16'h0000, 0,   16'h8000, 2'b00, 1'b0};
    vec[6] = '{20'h40000, 1'b0, 1'b1, 1'b0, 16'h0000, 254, 16'h0F0F, 2'b11, 1'b0};

    reset_n   = 1'b0;
    nec_ad_in = '0;
    nec_astb  = 1'b0;
    nec_rd_n  = 1'b1;
    nec_wr_n  = 1'b1;
    nec_io_n  = 1'b1;
    nec_ube_n = 1'b1;
    bus_rdata = '0;
    bus_ack   = 1'b0;
    tick();
    tick();
    check("rst_ready", 32'(nec_ready), 32'd1);
    check("rst_oe", 32'(nec_ad_oe), 32'd0);
    check("rst_dir", 32'(nec_ad_dir), 32'd0);
    check("rst_req", 32'(bus_req), 32'd0);
    check("rst_we", 32'(bus_we), 32'd0);
    check("rst_io", 32'(bus_io), 32'd0);
    check("rst_addr", 32'(bus_addr), 32'd0);
    check("rst_be", 32'(bus_be), 32'd0);
    check("rst_wdata", 32'(bus_wdata), 32'd0);
    check("rst_ad_out", 32'(nec_ad_out), 32'd0);
    check("rst_tmo", 32'(timeout), 32'd0);
    reset_n = 1'b1;
    tick();
    tick();
    check("idle_ready", 32'(nec_ready), 32'd1);

    for (int i = 0; i < 7; i++) run_txn(vec[i], $sformatf("v%0d", i));

    // read that is never acknowledged
    addr_phase(20'h54321, 1'b0, 1'b1, "to");
    strobe_fall(1'b0, 16'h0000, "to");
    n = 1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (bus_req !== 1'b1) break;
      n++;
    end
    check("to_req_len", 32'(n), 32'd255);
    check("to_pulse", 32'(timeout), 32'd1);
    check("to_ad_out", 32'(nec_ad_out), 32'hFFFF);
    check("to_oe", 32'(nec_ad_oe), 32'd1);
    check("to_ready", 32'(nec_ready), 32'd1);
    tick();
    check("to_pulse_end", 32'(timeout), 32'd0);
    txn_finish(1'b0, "to");

    // RD and WR asserted together
    addr_phase(20'h0F00F, 1'b1, 1'b1, "err");
    snap = req_cnt;
    nec_rd_n = 1'b0;
    nec_wr_n = 1'b0;
    tick();
    tick();
    check("err_rdy_wait", 32'(nec_ready), 32'd0);
    tick();
    check("err_rdy", 32'(nec_ready), 32'd1);
    tick();
    tick();
    check("err_no_req", 32'(req_cnt - snap), 32'd0);
    nec_rd_n = 1'b1;
    nec_wr_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("err_rdy_end", 32'(nec_ready), 32'd1);
    run_txn(vec[3], "err_next");

    // async reset while waiting for ack, then a late ack
    addr_phase(20'h33333, 1'b1, 1'b1, "rq");
    strobe_fall(1'b0, 16'h0000, "rq");
    tick();
    reset_n = 1'b0;
    #1;
    check("rq_rst_req", 32'(bus_req), 32'd0);
    check("rq_rst_ready", 32'(nec_ready), 32'd1);
    check("rq_rst_addr", 32'(bus_addr), 32'd0);
    nec_rd_n = 1'b1;
    tick();
    reset_n   = 1'b1;
    bus_ack   = 1'b1;
    bus_rdata = 16'h1234;
    tick();
    bus_ack   = 1'b0;
    check("late_ack_req", 32'(bus_req), 32'd0);
    check("late_ack_oe", 32'(nec_ad_oe), 32'd0);
    check("late_ack_rdy", 32'(nec_ready), 32'd1);
    check("late_ack_data", 32'(nec_ad_out), 32'd0);
    tick();
    tick();

    // async reset while read data is driven
    txn_start(vec[0], "rd");
    reset_n = 1'b0;
    #1;
    check("rd_rst_oe", 32'(nec_ad_oe), 32'd0);
    check("rd_rst_dir", 32'(nec_ad_dir), 32'd0);
    check("rd_rst_ad", 32'(nec_ad_out), 32'd0);
    check("rd_rst_ready", 32'(nec_ready), 32'd1);
    nec_rd_n = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    run_txn(vec[4], "post_rst");

    // second ASTB during DATA is ignored; a fresh one after release latches
    t = '{20'h11110, 1'b1, 1'b1, 1'b0, 16'h0000, 2, 16'hCAFE, 2'b01, 1'b0};
    txn_start(t, "b2b1");
    astb_pulse(20'h22222, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    check("b2b_addr_kept", 32'(bus_addr), 32'h11110);
    check("b2b_io_kept", 32'(bus_io), 32'd0);
    check("b2b_ready_kept", 32'(nec_ready), 32'd1);
    txn_finish(1'b0, "b2b1");
    t = '{20'h22223, 1'b0, 1'b0, 1'b0, 16'h0000, 1, 16'h600D, 2'b10, 1'b1};
    run_txn(t, "b2b2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench stalled");
  end

endmodule
